montexp_ctrl: RTL and testbench
===============================

MONTEXP_CTRL -- requirements
Module: montexp_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning limb width in bits.
REQ-002 SHALL have parameter S, default 4, meaning number of limbs per operand.
REQ-003 SHALL have parameter EBITS, default 64, meaning exponent width in bits.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE.
REQ-007 base_m  input  WIDTH x S  base in Montgomery form, sampled at accepted start.
REQ-008 one_m  input  WIDTH x S  R mod p, sampled at accepted start.
REQ-009 exp  input  EBITS  exponent, sampled at accepted start.
REQ-010 busy  output  1  high from the cycle after accepted start until done.
REQ-011 done  output  1  one-cycle pulse when result is valid.
REQ-012 result  output  WIDTH x S  final value; held until next accepted start.
REQ-013 ovf  output  1  sticky per operation; set if any captured mm_T[S] is non-zero.
REQ-014 mm_start  output  1  one-cycle pulse launching the shared Montgomery multiplier.
REQ-015 mm_a, mm_b  output  WIDTH x S each  multiplier operands; stable from mm_start until capture.
REQ-016 mm_T  input  WIDTH x (S+1)  multiplier result.
REQ-017 mm_done  input  1  multiplier completion pulse; mm_T is valid in the cycle after it.

Function
REQ-018 SHALL implement left-to-right square-and-multiply: acc=one_m, then for i=EBITS-1 down to 0: acc=MM(acc,acc); if exp[i]: acc=MM(acc,base_m).
REQ-019 FSM states: IDLE, SQ_REQ, SQ_WAIT, SQ_CAP, MUL_REQ, MUL_WAIT, MUL_CAP, CV_REQ, CV_WAIT, CV_CAP, DONE.
REQ-020 IDLE -> SQ_REQ on start; latch operands, bit index=EBITS-1, clear ovf.
REQ-021 *_REQ SHALL assert mm_start for exactly one cycle, drive operands, and go to *_WAIT next cycle.
REQ-022 *_WAIT SHALL hold until mm_done=1, then go to *_CAP; no cycle limit.
REQ-023 *_CAP SHALL latch mm_T[S-1:0] into acc and OR (mm_T[S]!=0) into ovf.
REQ-024 SQ_CAP -> MUL_REQ if exp[index]=1, else advance the bit; MUL_CAP advances the bit.
REQ-025 Bit advance: if index=0 go to CV_REQ (or DONE, per REQ-033), else index-1 and go to SQ_REQ.
REQ-026 DONE SHALL copy acc to result, pulse done for one cycle, drop busy, and return to IDLE.
REQ-027 start while busy SHALL be ignored; mm_done outside *_WAIT SHALL be ignored.
REQ-028 exp=0 SHALL still perform EBITS squarings of one_m; result=one_m (pre-conversion).
REQ-029 Multiplier operations per job = EBITS + popcount(exp) (+1 with conversion).
REQ-030 mm_T[S] SHALL NOT be used as data; no conditional subtraction is done here.

Reset
REQ-031 On rst: state=IDLE; busy, done, mm_start, ovf=0; result, mm_a, mm_b, acc=0.
REQ-032 rst mid-operation SHALL abort immediately; no done pulse; a later mm_done SHALL be ignored.

Configuration
REQ-033 With MONTEXP_FINAL_CONVERT_EN defined: CV_REQ computes MM(acc, 1), where 1 is limb0=1 and others 0, so the result leaves Montgomery form. Without it: CV_* states are absent and bit advance at index 0 goes directly to DONE.

Structure
REQ-034 Shared package montexp_pkg SHALL hold the FSM state enum, the limb-array typedef, and the constant ONE (limb0=1).
REQ-035 No sub-module is required; the multiplier SHALL stay external, so it can be shared.

Verification (WIDTH=8, S=1, EBITS=4, p=13, R mod 13=9, behavioural MM model with a 10-cycle latency)
REQ-036 base_m=5 (2), exp=5, CONVERT_EN defined -> result=6, done once, 7 mm_start pulses.
REQ-037 Same stimulus, CONVERT_EN undefined -> result=2 (6*R mod 13), 6 mm_start pulses.
REQ-038 exp=0, CONVERT_EN defined -> result=1, 5 mm_start pulses, ovf=0.
REQ-039 start re-pulsed while busy and spurious mm_done in SQ_REQ -> ignored; result still 6.
REQ-040 rst asserted during MUL_WAIT, then release and start exp=1 -> busy=0 after reset; second job gives result=2 with no stale capture.
REQ-041 Model returns mm_T[S]=1 on one operation -> ovf=1 at done, cleared on next start.

Source files
------------

// File: rtl/montexp_pkg.sv
// Shared FSM state, limb-array type and constants for the Montgomery exponentiation controller.
// Defining MONTEXP_FINAL_CONVERT_EN adds the CV_* states (final conversion out of Montgomery form).
package montexp_pkg;

  localparam int unsigned LIMB_W = 32;
  localparam int unsigned LIMBS  = 4;

  typedef logic [LIMBS-1:0][LIMB_W-1:0] limbs_t;

  // Multiplicative identity in plain form: limb0 = 1, all other limbs 0.
  localparam limbs_t ONE = limbs_t'(1);

  typedef enum logic [3:0] {
    IDLE,
    SQ_REQ,
    SQ_WAIT,
    SQ_CAP,
    MUL_REQ,
    MUL_WAIT,
    MUL_CAP,
`ifdef MONTEXP_FINAL_CONVERT_EN
    CV_REQ,
    CV_WAIT,
    CV_CAP,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/montexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external, shareable Montgomery multiplier.
// Optional MONTEXP_FINAL_CONVERT_EN appends MM(acc, 1) to return the result in plain form.
module montexp_ctrl
  import montexp_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned S     = 4,
  parameter int unsigned EBITS = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [WIDTH*S-1:0]         base_m,
  input  logic [WIDTH*S-1:0]         one_m,
  input  logic [EBITS-1:0]           exp,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH*S-1:0]         result,
  output logic                       ovf,
  output logic                       mm_start,
  output logic [WIDTH*S-1:0]         mm_a,
  output logic [WIDTH*S-1:0]         mm_b,
  input  logic [WIDTH*(S+1)-1:0]     mm_T,
  input  logic                       mm_done
);

  localparam int unsigned OPW   = WIDTH * S;
  localparam int unsigned IDX_W = (EBITS > 1) ? $clog2(EBITS) : 1;

`ifdef MONTEXP_FINAL_CONVERT_EN
  localparam logic [OPW-1:0] ONE_V = OPW'(ONE);
  localparam state_t LAST = CV_REQ;
`else
  localparam state_t LAST = DONE;
`endif

  state_t             state, state_n;
  logic [OPW-1:0]     acc, base_r;
  logic [EBITS-1:0]   exp_r;
  logic [IDX_W-1:0]   idx;
  logic               cap, dec_idx;
  state_t             adv_state;

  assign busy = (state != IDLE);
  assign mm_a = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mm_start  = 1'b0;
    mm_b      = acc;
    cap       = 1'b0;
    dec_idx   = 1'b0;
    adv_state = (idx == '0) ? LAST : SQ_REQ;
    case (state)
      IDLE:     if (start) state_n = SQ_REQ;
      SQ_REQ: begin
        mm_start = 1'b1;
        state_n  = SQ_WAIT;
      end
      SQ_WAIT:  if (mm_done) state_n = SQ_CAP;
      SQ_CAP: begin
        cap = 1'b1;
        if (exp_r[idx]) begin
          state_n = MUL_REQ;
        end else begin
          state_n = adv_state;
          dec_idx = 1'b1;
        end
      end
      MUL_REQ: begin
        mm_start = 1'b1;
        mm_b     = base_r;
        state_n  = MUL_WAIT;
      end
      MUL_WAIT: begin
        mm_b = base_r;
        if (mm_done) state_n = MUL_CAP;
      end
      MUL_CAP: begin
        mm_b    = base_r;
        cap     = 1'b1;
        state_n = adv_state;
        dec_idx = 1'b1;
      end
`ifdef MONTEXP_FINAL_CONVERT_EN
      CV_REQ: begin
        mm_start = 1'b1;
        mm_b     = ONE_V;
        state_n  = CV_WAIT;
      end
      CV_WAIT: begin
        mm_b = ONE_V;
        if (mm_done) state_n = CV_CAP;
      end
      CV_CAP: begin
        mm_b    = ONE_V;
        cap     = 1'b1;
        state_n = DONE;
      end
`endif
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  // Index wraps after bit 0 is consumed; it is reloaded on the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      base_r <= '0;
      exp_r  <= '0;
      idx    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        acc    <= one_m;
        base_r <= base_m;
        exp_r  <= exp;
        idx    <= IDX_W'(EBITS - 1);
        ovf    <= 1'b0;
      end else begin
        if (cap) begin
          acc <= mm_T[OPW-1:0];
          ovf <= ovf | (mm_T[WIDTH*(S+1)-1:OPW] != '0);
        end
        if (dec_idx) idx <= idx - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= (state == DONE);
      if (state == DONE) result <= acc;
    end
  end

endmodule

// File: tb/tb_montexp_ctrl.sv
// Randomized bench for montexp_ctrl (WIDTH=8, S=1, EBITS=4, p=13, R mod p=9) with a 10-cycle MM model.
// Expected results come from plain modular exponentiation of the decoded base.
module tb_montexp_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned S     = 1;
  localparam int unsigned EBITS = 4;
  localparam int unsigned P     = 13;
  localparam int unsigned RMOD  = 9;
  localparam int unsigned RINV  = 3;
`ifdef MONTEXP_FINAL_CONVERT_EN
  localparam int unsigned CONV = 1;
`else
  localparam int unsigned CONV = 0;
`endif

  logic                   clk = 1'b0;
  logic                   rst, start;
  logic [WIDTH*S-1:0]     base_m, one_m;
  logic [EBITS-1:0]       exp;
  logic                   busy, done, ovf, mm_start, mm_done;
  logic [WIDTH*S-1:0]     result, mm_a, mm_b;
  logic [WIDTH*(S+1)-1:0] mm_T;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_mm_start = 0;
  bit          inject_spur = 1'b0;
  bit          inject_ovf = 1'b0;
  int unsigned ovf_op = 0;

  always #5 clk = ~clk;

  montexp_ctrl #(.WIDTH(WIDTH), .S(S), .EBITS(EBITS)) dut (
    .clk(clk), .rst(rst), .start(start), .base_m(base_m), .one_m(one_m), .exp(exp),
    .busy(busy), .done(done), .result(result), .ovf(ovf), .mm_start(mm_start),
    .mm_a(mm_a), .mm_b(mm_b), .mm_T(mm_T), .mm_done(mm_done)
  );

  // Multiplier model: MM(a,b) = a*b*R^-1 mod p; done pulse after 10 cycles, data valid the cycle after.
  initial begin
    int unsigned cd;
    bit          pend, fire;
    logic [7:0]  val, top;
    mm_done = 1'b0;
    mm_T    = '0;
    pend    = 1'b0;
    fire    = 1'b0;
    cd      = 0;
    val     = '0;
    top     = '0;
    forever begin
      @(posedge clk);
      #1;
      mm_done = 1'b0;
      if (fire) begin
        mm_T = {top, val};
        fire = 1'b0;
      end
      if (pend) begin
        cd--;
        if (cd == 0) begin
          pend    = 1'b0;
          mm_done = 1'b1;
          mm_T    = 16'h5AA5;
          fire    = 1'b1;
        end
      end
      if (mm_start) begin
        n_mm_start++;
        val  = 8'((int'(mm_a) * int'(mm_b) * RINV) % P);
        top  = (inject_ovf && n_mm_start == ovf_op) ? 8'd1 : 8'd0;
        pend = 1'b1;
        cd   = 10;
        if (inject_spur) begin
          mm_done     = 1'b1;
          mm_T        = 16'h01AB;
          inject_spur = 1'b0;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic int unsigned expect_result(input int unsigned bm, input int unsigned e);
    int unsigned b = (bm * RINV) % P;
    int unsigned r = 1;
    for (int unsigned k = 0; k < e; k++) r = (r * b) % P;
    return (CONV != 0) ? r : (r * RMOD) % P;
  endfunction

  task automatic run_job(input int unsigned bm, input int unsigned e, input bit want_ovf,
                         input bit disturb, input string tag);
    int unsigned cyc;
    @(negedge clk);
    base_m     = 8'(bm);
    exp        = 4'(e);
    one_m      = 8'(RMOD);
    start      = 1'b1;
    n_mm_start = 0;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, 64'(busy), 64'd1);
    check({tag, " ovf_clr"}, 64'(ovf), 64'd0);
    cyc = 0;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (disturb && cyc == 20) begin
        start  = 1'b1;
        base_m = 8'd0;
        exp    = 4'hF;
      end else if (disturb && cyc == 21) begin
        start = 1'b0;
      end
    end
    if (!done) begin
      check({tag, " timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, " result"}, 64'(result), 64'(expect_result(bm, e)));
    check({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check({tag, " ovf"}, 64'(ovf), 64'(want_ovf));
    check({tag, " mm_ops"}, 64'(n_mm_start), 64'(EBITS + $countones(4'(e)) + CONV));
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int unsigned cyc, seen;
    rst    = 1'b1;
    start  = 1'b0;
    base_m = '0;
    one_m  = '0;
    exp    = '0;
    repeat (3) @(negedge clk);
    check("rst busy", 64'(busy), 64'd0);
    check("rst done", 64'(done), 64'd0);
    check("rst ovf", 64'(ovf), 64'd0);
    check("rst mm_start", 64'(mm_start), 64'd0);
    check("rst result", 64'(result), 64'd0);
    check("rst mm_a", 64'(mm_a), 64'd0);
    check("rst mm_b", 64'(mm_b), 64'd0);
    rst = 1'b0;

    run_job(5, 5, 1'b0, 1'b0, "e5");
    run_job(5, 0, 1'b0, 1'b0, "e0");
    inject_spur = 1'b1;
    run_job(5, 5, 1'b0, 1'b1, "disturbed");

    inject_ovf = 1'b1;
    ovf_op     = 3;
    run_job(5, 5, 1'b1, 1'b0, "ovf_set");
    inject_ovf = 1'b0;
    run_job(5, 5, 1'b0, 1'b0, "ovf_clear");

    // Abort during the final multiply (5th operation for exp=1), then rerun.
    @(negedge clk);
    base_m     = 8'd5;
    exp        = 4'd1;
    one_m      = 8'(RMOD);
    start      = 1'b1;
    n_mm_start = 0;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (n_mm_start < EBITS + 1 && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("abort reached mul", 64'(n_mm_start), 64'(EBITS + 1));
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 64'(busy), 64'd0);
    check("abort done", 64'(done), 64'd0);
    check("abort result", 64'(result), 64'd0);
    rst  = 1'b0;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done || busy) seen++;
    end
    check("abort stale ignored", 64'(seen), 64'd0);
    run_job(5, 1, 1'b0, 1'b0, "post_abort");

    for (int unsigned i = 0; i < 8; i++) begin
      run_job($urandom_range(0, P - 1), $urandom_range(0, 15), 1'b0, 1'b0, $sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
